clk_div_sched: RTL and testbench

Divide-ratio scheduler for the even clock divider chain. It runs a free-running 3-bit divide counter on `clk_in` and produces one registered output clock, selectable as ÷2, ÷4, ÷8 or gated off. A requester asks for a new ratio over a valid/ready handshake, and the block defers the switch to the common alignment edge so `clk_out` never glitches or produces a runt pulse. It sits between the clock-configuration register logic and the downstream consumers of the divided clock.

---
 rtl/clk_div_pkg.sv | 28 ++
 rtl/clk_div_sched.sv | 83 ++++++++
 tb/tb_clk_div_sched.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the even clock divider scheduler: ratio codes,
// FSM states and the counter value that marks the common alignment edge.
package clk_div_pkg;

  localparam logic [1:0] SEL_DIV2 = 2'd0;
  localparam logic [1:0] SEL_DIV4 = 2'd1;
  localparam logic [1:0] SEL_DIV8 = 2'd2;
  localparam logic [1:0] SEL_OFF  = 2'd3;

  localparam logic [2:0] CNT_ALIGN = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_ALIGN = 2'd1,
    ST_DONE       = 2'd2
  } state_t;

  // Divided-clock level for a given ratio code and post-edge counter value.
  function automatic logic div_bit(input logic [1:0] sel, input logic [2:0] n);
    case (sel)
      SEL_DIV2: return n[0];
      SEL_DIV4: return n[1];
      SEL_DIV8: return n[2];
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/clk_div_sched.sv
// Divide-ratio scheduler: free-running 3-bit counter, registered divided clock,
// and a handshake FSM that defers ratio changes to the alignment edge.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter logic [1:0] INIT_SEL = 2'd0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_sel,
  output logic       req_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] cur_sel,
  output logic       clk_out
);

  state_t     state, state_nxt;
  logic [2:0] cnt;
  logic [2:0] cnt_nxt;
  logic [1:0] cur_sel_nxt;
  logic [1:0] pend_sel, pend_sel_nxt;
  logic       clk_out_nxt;
  logic       at_align;

  assign cnt_nxt  = cnt + 3'd1;
  assign at_align = (cnt == CNT_ALIGN);

  always_comb begin
    state_nxt    = state;
    cur_sel_nxt  = cur_sel;
    pend_sel_nxt = pend_sel;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_sel == cur_sel) begin
            state_nxt = ST_DONE;
          end else if (at_align) begin
            cur_sel_nxt = req_sel;
            state_nxt   = ST_DONE;
          end else begin
            pend_sel_nxt = req_sel;
            state_nxt    = ST_WAIT_ALIGN;
          end
        end
      end
      ST_WAIT_ALIGN: begin
        if (at_align) begin
          cur_sel_nxt = pend_sel;
          state_nxt   = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The output level uses the ratio taking effect at this same edge, so a
  // switch at the alignment edge starts straight into the new low phase.
  assign clk_out_nxt = div_bit(cur_sel_nxt, cnt_nxt);

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= 3'd0;
      cur_sel  <= INIT_SEL;
      pend_sel <= 2'd0;
      clk_out  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_sel  <= cur_sel_nxt;
      pend_sel <= pend_sel_nxt;
      clk_out  <= clk_out_nxt;
    end
  end

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed vector table, hand-written corner
// sequences and randomized requests against an edge-timeline reference model.
module tb_clk_div_sched;

  localparam logic [1:0] INIT = 2'd0;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [1:0] req_sel;
  logic       req_ready;
  logic       busy;
  logic       done;
  logic [1:0] cur_sel;
  logic       clk_out;

  clk_div_sched #(.INIT_SEL(INIT)) dut (
    .clk_in   (clk_in),
    .rst      (rst),
    .req_valid(req_valid),
    .req_sel  (req_sel),
    .req_ready(req_ready),
    .busy     (busy),
    .done     (done),
    .cur_sel  (cur_sel),
    .clk_out  (clk_out)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model: edges are numbered from reset release; the counter value
  // after edge k is k mod 8, and request outcomes are scheduled as edge indices.
  int         ecount;
  logic [1:0] m_sel;
  logic [1:0] m_pend;
  logic       m_pend_act;
  int         m_switch_edge;
  int         m_done_edge;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0d, required %0d", name, ecount, act, exp);
    end
  endtask

  task automatic model_reset();
    ecount        = 0;
    m_sel         = INIT;
    m_pend        = 2'd0;
    m_pend_act    = 1'b0;
    m_switch_edge = -1;
    m_done_edge   = -1;
  endtask

  task automatic model_edge(input logic v, input logic [1:0] s);
    int cnt_before;
    int k;
    cnt_before = ecount % 8;
    ecount++;
    k = ecount;
    if (v && (k - 1) > m_done_edge) begin
      if (s == m_sel) begin
        m_done_edge = k;
      end else if (cnt_before == 7) begin
        m_sel       = s;
        m_done_edge = k;
      end else begin
        m_pend        = s;
        m_pend_act    = 1'b1;
        m_switch_edge = k + (7 - cnt_before);
        m_done_edge   = m_switch_edge;
      end
    end
    if (m_pend_act && k == m_switch_edge) begin
      m_sel      = m_pend;
      m_pend_act = 1'b0;
    end
  endtask

  function automatic logic exp_clk();
    if (m_sel == 2'd3) return 1'b0;
    return 1'(((ecount % 8) >> int'(m_sel)) & 1);
  endfunction

  task automatic check_model();
    logic eb;
    eb = (ecount <= m_done_edge);
    chk("m_clk_out", int'(clk_out), int'(exp_clk()));
    chk("m_cur_sel", int'(cur_sel), int'(m_sel));
    chk("m_busy", int'(busy), int'(eb));
    chk("m_ready", int'(req_ready), int'(!eb));
    chk("m_done", int'(done), int'(ecount == m_done_edge));
  endtask

  task automatic step(input logic v, input logic [1:0] s);
    req_valid = v;
    req_sel   = s;
    @(posedge clk_in);
    model_edge(v, s);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       v;
    logic [1:0] s;
    logic       e_clk;
    logic [1:0] e_sel;
    logic       e_busy;
    logic       e_done;
  } vec_t;

  vec_t tbl[22];

  initial begin
    // edges 1-7: /2 running; edge 3 requests /8 with cnt=2 before the edge
    tbl[0]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 2'd2, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 2'd0, 1'b1, 2'd0, 1'b1, 1'b0};
    // edge 8: alignment edge, /8 takes effect, done follows
    tbl[7]  = '{1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b1};
    tbl[8]  = '{1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 2'd0, 1'b1, 2'd2, 1'b0, 1'b0};
    // edge 16: /4 requested with cnt=7, switches at the accepting edge
    tbl[15] = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b1};
    tbl[16] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0};
    tbl[19] = '{1'b0, 2'd0, 1'b0, 2'd1, 1'b0, 1'b0};
    // edge 21: same-code request, done next cycle, waveform unchanged
    tbl[20] = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b1, 1'b1};
    tbl[21] = '{1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0};
  end

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    req_sel   = 2'd0;
    model_reset();
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_cur_sel", int'(cur_sel), int'(INIT));
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b1;

    for (int i = 0; i < 22; i++) begin
      step(tbl[i].v, tbl[i].s);
      chk("tbl_clk_out", int'(clk_out), int'(tbl[i].e_clk));
      chk("tbl_cur_sel", int'(cur_sel), int'(tbl[i].e_sel));
      chk("tbl_busy", int'(busy), int'(tbl[i].e_busy));
      chk("tbl_done", int'(done), int'(tbl[i].e_done));
    end

    // Off, then back on as /2
    step(1'b1, 2'd3);
    for (int i = 0; i < 12 && !done; i++) step(1'b0, 2'd0);
    chk("off_done", int'(done), 1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'd0);
      chk("off_held_low", int'(clk_out), 0);
    end
    step(1'b1, 2'd0);
    for (int i = 0; i < 12 && !done; i++) step(1'b0, 2'd0);
    chk("on_done", int'(done), 1);
    chk("on_align_low", int'(clk_out), 0);
    step(1'b0, 2'd0);
    chk("on_first_rise", int'(clk_out), 1);

    // req_valid held high with changing codes while busy
    for (int i = 0; i < 40; i++) step(1'b1, 2'($urandom_range(0, 3)));
    for (int i = 0; i < 12 && busy; i++) step(1'b0, 2'd0);
    chk("held_idle", int'(busy), 0);

    // Reset during WAIT_ALIGN: land acceptance on cnt=2 with a different code
    for (int i = 0; i < 16 && !((ecount % 8) == 2 && ecount > m_done_edge); i++)
      step(1'b0, 2'd0);
    step(1'b1, (m_sel == 2'd2) ? 2'd1 : 2'd2);
    chk("wait_busy", int'(busy), 1);
    chk("wait_no_done", int'(done), 0);
    step(1'b0, 2'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_cur_sel", int'(cur_sel), int'(INIT));
    chk("mid_rst_clk_out", int'(clk_out), 0);
    repeat (3) begin
      @(posedge clk_in);
      #1;
      chk("rst_hold_done", int'(done), 0);
      chk("rst_hold_clk_out", int'(clk_out), 0);
    end
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 2'd0);

    // Randomized requests against the model
    for (int i = 0; i < 1500; i++) begin
      logic v;
      v = ($urandom_range(0, 2) == 0);
      step(v, 2'($urandom_range(0, 3)));
    end

    req_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
